// File: rtl/tmr_pkg.sv
// Shared definitions for the triple-modular-redundant counter: replica count,
// majority helper and replica index type.
package tmr_pkg;

    localparam int NREP = 3;

    typedef logic [1:0] rep_idx_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_voter3.sv
// Bitwise majority voter over three replicas with per-replica disagreement
// flags and an all-replicas-differ indication.
module tmr_voter3
    import tmr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r0,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] v,
    output logic [2:0]       mismatch,
    output logic             all_differ
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        assign v[b] = maj3(r0[b], r1[b], r2[b]);
    end

    // Disagreement flags against the vote and the pairwise all-differ test
    always_comb begin
        mismatch[0] = (r0 != v);
        mismatch[1] = (r1 != v);
        mismatch[2] = (r2 != v);
        all_differ  = (r0 != r1) && (r0 != r2) && (r1 != r2);
    end

endmodule

// File: rtl/tmr_mod_counter.sv
// Radiation-hardened up/down modulo counter: three scrubbed replicas, majority
// vote, per-replica upset accounting and a fault-injection port.
module tmr_mod_counter
    import tmr_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] MAX_COUNT  = {WIDTH{1'b1}},
    parameter int               ERR_W      = 8,
    parameter int               ERR_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 up_dn,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    input  logic [2:0]           inj_en,
    input  logic [WIDTH-1:0]     inj_bits,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     q,
    output logic                 tc,
    output logic [2:0]           mismatch,
    output logic [2:0]           err_sticky,
    output logic [3*ERR_W-1:0]   err_cnt,
    output logic                 uncorrectable,
    output logic                 alarm
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_LIM = ERR_W'(ERR_THRESH);

    logic [WIDTH-1:0] rep_r [NREP];
    logic             sticky_r [NREP];
    logic [ERR_W-1:0] cnt_r [NREP];
    logic [WIDTH-1:0] vote_s;
    logic [WIDTH-1:0] base_s;
    logic [2:0]       mismatch_s;
    logic [2:0]       alarm_s;
    logic             all_differ_s;
    logic             wrap_s;
    logic             tc_r;
    logic             unc_r;

    tmr_voter3 #(.WIDTH(WIDTH)) u_voter (
        .r0         (rep_r[0]),
        .r1         (rep_r[1]),
        .r2         (rep_r[2]),
        .v          (vote_s),
        .mismatch   (mismatch_s),
        .all_differ (all_differ_s)
    );

    // Common next value derived from the vote; a vote above MAX_COUNT steps up to 0
    always_comb begin
        base_s = vote_s;
        wrap_s = 1'b0;
        if (load) begin
            base_s = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (vote_s == MAX_COUNT) begin
                    base_s = {WIDTH{1'b0}};
                    wrap_s = 1'b1;
                end else if (vote_s > MAX_COUNT) begin
                    base_s = {WIDTH{1'b0}};
                end else begin
                    base_s = vote_s + WIDTH'(1);
                end
            end else begin
                if (vote_s == {WIDTH{1'b0}}) begin
                    base_s = MAX_COUNT;
                    wrap_s = 1'b1;
                end else begin
                    base_s = vote_s - WIDTH'(1);
                end
            end
        end else begin
            base_s = vote_s;
        end
    end

    for (genvar i = 0; i < NREP; i++) begin : g_rep
        // Replica register, rebuilt from the vote every edge unless injected
        always_ff @(posedge clk) begin
            if (rst) begin
                rep_r[i] <= {WIDTH{1'b0}};
            end else if (inj_en[i]) begin
                rep_r[i] <= rep_r[i] ^ inj_bits;
            end else begin
                rep_r[i] <= base_s;
            end
        end

        // Sticky flag and saturating count; a fresh mismatch beats clr_err
        always_ff @(posedge clk) begin
            if (rst) begin
                sticky_r[i] <= 1'b0;
                cnt_r[i]    <= {ERR_W{1'b0}};
            end else if (mismatch_s[i]) begin
                sticky_r[i] <= 1'b1;
                if (clr_err) begin
                    cnt_r[i] <= ERR_W'(1);
                end else if (cnt_r[i] == ERR_MAX) begin
                    cnt_r[i] <= ERR_MAX;
                end else begin
                    cnt_r[i] <= cnt_r[i] + ERR_W'(1);
                end
            end else if (clr_err) begin
                sticky_r[i] <= 1'b0;
                cnt_r[i]    <= {ERR_W{1'b0}};
            end else begin
                sticky_r[i] <= sticky_r[i];
                cnt_r[i]    <= cnt_r[i];
            end
        end

        assign err_sticky[i]              = sticky_r[i];
        assign err_cnt[i*ERR_W +: ERR_W]  = cnt_r[i];
        assign alarm_s[i]                 = (cnt_r[i] >= ERR_LIM);
    end

    // Wrap pulse and the sticky uncorrectable flag
    always_ff @(posedge clk) begin
        if (rst) begin
            tc_r  <= 1'b0;
            unc_r <= 1'b0;
        end else begin
            tc_r <= wrap_s && (inj_en == 3'b000);
            if (all_differ_s) begin
                unc_r <= 1'b1;
            end else if (clr_err) begin
                unc_r <= 1'b0;
            end else begin
                unc_r <= unc_r;
            end
        end
    end

    assign q             = vote_s;
    assign tc            = tc_r;
    assign mismatch      = mismatch_s;
    assign uncorrectable = unc_r;
    assign alarm         = |alarm_s;

endmodule

// File: tb/tb_tmr_mod_counter.sv
// Directed bench for tmr_mod_counter (WIDTH=8, MAX_COUNT=9, ERR_THRESH=4):
// a vector table for counting/loading and hand sequences for upset handling.
module tb_tmr_mod_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        up_dn = 1'b1;
    logic        load = 1'b0;
    logic [7:0]  load_val = 8'd0;
    logic [2:0]  inj_en = 3'b000;
    logic [7:0]  inj_bits = 8'd0;
    logic        clr_err = 1'b0;
    logic [7:0]  q;
    logic        tc;
    logic [2:0]  mismatch;
    logic [2:0]  err_sticky;
    logic [23:0] err_cnt;
    logic        uncorrectable;
    logic        alarm;

    int n_tests = 0;
    int n_fail  = 0;

    tmr_mod_counter #(
        .WIDTH(8), .MAX_COUNT(8'd9), .ERR_W(8), .ERR_THRESH(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .inj_en(inj_en), .inj_bits(inj_bits),
        .clr_err(clr_err), .q(q), .tc(tc), .mismatch(mismatch),
        .err_sticky(err_sticky), .err_cnt(err_cnt),
        .uncorrectable(uncorrectable), .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       up_dn;
        logic       load;
        logic [7:0] load_val;
        logic [7:0] exp_q;
        logic       exp_tc;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic r, logic e, logic u, logic l,
                                logic [7:0] lv, logic [7:0] eq, logic et);
        vec_t v;
        v.rst = r; v.en = e; v.up_dn = u; v.load = l; v.load_val = lv;
        v.exp_q = eq; v.exp_tc = et;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, return 1 time unit after the rising edge
    task automatic step(input logic r, input logic e, input logic u, input logic l,
                        input logic [7:0] lv, input logic [2:0] ie, input logic [7:0] ib,
                        input logic ce);
        @(negedge clk);
        rst = r; en = e; up_dn = u; load = l; load_val = lv;
        inj_en = ie; inj_bits = ib; clr_err = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'b000, 8'd0, 1'b0);
    endtask

    task automatic inject(input logic [2:0] ie, input logic [7:0] ib);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, ie, ib, 1'b0);
    endtask

    task automatic clear();
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'b000, 8'd0, 1'b1);
    endtask

    initial begin
        vecs[0] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        for (int i = 1; i <= 9; i++) vecs[i] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'(i), 1'b0);
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   8'd0, 1'b1);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   8'd9, 1'b1);
        vecs[13] = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'd200, 8'd9, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'd5,   8'd5, 1'b0);
        vecs[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   8'd4, 1'b0);
        vecs[16] = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'd9,   8'd9, 1'b0);
        vecs[17] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   8'd0, 1'b1);
        vecs[18] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd0,   8'd0, 1'b0);
        vecs[19] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   8'd9, 1'b1);

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].up_dn, vecs[i].load,
                 vecs[i].load_val, 3'b000, 8'd0, 1'b0);
            chk($sformatf("vec%0d q", i), 32'(q), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d tc", i), 32'(tc), 32'(vecs[i].exp_tc));
            chk($sformatf("vec%0d mismatch", i), 32'(mismatch), 32'd0);
            if (i == 0) begin
                chk("reset err_cnt", 32'(err_cnt), 32'd0);
                chk("reset sticky", 32'(err_sticky), 32'd0);
                chk("reset unc", 32'(uncorrectable), 32'd0);
                chk("reset alarm", 32'(alarm), 32'd0);
            end
        end

        // Bring count back to 0 (q=9 after the table)
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3'b000, 8'd0, 1'b0);
        chk("pre q", 32'(q), 32'd0);

        // Single upset in replica 1 while idle
        inject(3'b010, 8'h81);
        chk("inj1 q", 32'(q), 32'd0);
        chk("inj1 mismatch", 32'(mismatch), 32'b010);
        chk("inj1 tc", 32'(tc), 32'd0);
        idle();
        chk("scrub1 mismatch", 32'(mismatch), 32'd0);
        chk("scrub1 sticky", 32'(err_sticky), 32'b010);
        chk("scrub1 err_cnt", 32'(err_cnt), 32'h000100);
        chk("scrub1 q", 32'(q), 32'd0);
        clear();
        chk("clr1 sticky", 32'(err_sticky), 32'd0);
        chk("clr1 err_cnt", 32'(err_cnt), 32'd0);

        // Upset into replica 0 together with a count step
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3'b001, 8'h03, 1'b0);
        chk("inj_en q", 32'(q), 32'd1);
        chk("inj_en mismatch", 32'(mismatch), 32'b001);
        idle();
        chk("inj_en scrub q", 32'(q), 32'd1);
        chk("inj_en cnt0", 32'(err_cnt), 32'h000001);
        chk("inj_en alarm", 32'(alarm), 32'd0);
        for (int k = 2; k <= 4; k++) begin
            inject(3'b001, 8'h04);
            idle();
            chk($sformatf("thr%0d err_cnt", k), 32'(err_cnt), 32'(k));
            chk($sformatf("thr%0d alarm", k), 32'(alarm), (k >= 4) ? 32'd1 : 32'd0);
        end
        chk("thr q", 32'(q), 32'd1);
        clear();
        chk("clr2 err_cnt", 32'(err_cnt), 32'd0);
        chk("clr2 alarm", 32'(alarm), 32'd0);

        // clr_err coinciding with a mismatch keeps flag and count at 1
        inject(3'b100, 8'h01);
        clear();
        chk("clrwin sticky", 32'(err_sticky), 32'b100);
        chk("clrwin err_cnt", 32'(err_cnt), 32'h010000);
        clear();
        chk("clr3 err_cnt", 32'(err_cnt), 32'd0);

        // Drive all three replicas apart: {0x31,0x11,0x21}
        inject(3'b011, 8'h10);
        chk("dbl q", 32'(q), 32'h11);
        chk("dbl mismatch", 32'(mismatch), 32'b100);
        inject(3'b101, 8'h20);
        chk("tri unc early", 32'(uncorrectable), 32'd0);
        chk("tri mismatch", 32'(mismatch), 32'b110);
        idle();
        chk("tri unc", 32'(uncorrectable), 32'd1);
        chk("tri q", 32'(q), 32'h31);
        idle();
        chk("tri unc hold", 32'(uncorrectable), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3'b000, 8'd0, 1'b0);
        chk("over-max up q", 32'(q), 32'd0);
        chk("over-max up tc", 32'(tc), 32'd0);
        clear();
        chk("tri unc clr", 32'(uncorrectable), 32'd0);

        // Reset overrides injection, load, count and bookkeeping
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd7, 3'b000, 8'd0, 1'b0);
        inject(3'b001, 8'h01);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'd5, 3'b111, 8'hFF, 1'b0);
        chk("rst q", 32'(q), 32'd0);
        chk("rst tc", 32'(tc), 32'd0);
        chk("rst mismatch", 32'(mismatch), 32'd0);
        chk("rst sticky", 32'(err_sticky), 32'd0);
        chk("rst err_cnt", 32'(err_cnt), 32'd0);
        chk("rst unc", 32'(uncorrectable), 32'd0);
        chk("rst alarm", 32'(alarm), 32'd0);
        idle();
        chk("post rst err_cnt", 32'(err_cnt), 32'd0);
        chk("post rst q", 32'(q), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tmr_mod_counter.md
# tmr_mod_counter

Parametrised triple-modular-redundant up/down modulo counter with continuous scrubbing, per-replica error accounting and a built-in fault-injection port. It replaces the fixed 32-bit TMR counter wherever a radiation-hardened counter is needed (timers, event counters, sequence numbers). It adds configurable width and modulus, direction, load, and observability of upsets. It sits between control logic and any consumer of a hardened count value.

## Interface
- `WIDTH`, 32: counter width in bits.
- `MAX_COUNT`, 2**WIDTH-1: terminal value; counting is modulo MAX_COUNT+1. Must satisfy 1 ≤ MAX_COUNT ≤ 2**WIDTH-1.
- `ERR_W`, 8: width of each per-replica error counter.
- `ERR_THRESH`, 4: alarm threshold, 1 ≤ ERR_THRESH ≤ 2**ERR_W-1.
- `clk`  in  1  clock. All logic is clocked by the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable.
- `up_dn`  in  1  direction: 1 counts up, 0 counts down.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  WIDTH  load value.
- `inj_en`  in  3  per-replica fault-injection strobe.
- `inj_bits`  in  WIDTH  XOR mask applied to the injected replica(s).
- `clr_err`  in  1  clears the sticky flags, error counters and `uncorrectable`.
- `q`  out  WIDTH  voted count.
- `tc`  out  1  registered one-cycle wrap pulse.
- `mismatch`  out  3  combinational flag, asserted while replica i differs from the vote.
- `err_sticky`  out  3  registered sticky mismatch flags.
- `err_cnt`  out  3*ERR_W  saturating per-replica error counts. Replica i occupies `[i*ERR_W +: ERR_W]`.
- `uncorrectable`  out  1  sticky flag; set when all three replicas differ pairwise.
- `alarm`  out  1  combinational; asserted when any `err_cnt` slice is ≥ ERR_THRESH.

## Operation
- Replica registers r0, r1, r2. The vote v = bitwise majority of the three; `q` = v.
- `mismatch[i]` = (r_i != v). The all-differ condition = r0≠r1 ∧ r0≠r2 ∧ r1≠r2.
- Every replica's next value is computed from v, never from its own r_i. This scrubs any single upset on the next edge, including while idle.
- Per-replica next value, in priority order:
  - `rst`: 0.
  - `inj_en[i]`: r_i ^ inj_bits.
  - `load`: min(load_val, MAX_COUNT).
  - `en`, up: v==MAX_COUNT ? 0 : v+1.
  - `en`, down: v==0 ? MAX_COUNT : v-1.
  - Otherwise: v.
- Step arithmetic is WIDTH-bit. Wrap is governed only by MAX_COUNT. If v > MAX_COUNT (an uncorrectable vote), stepping up yields 0 and stepping down yields v-1.
- `tc` is registered 1 on the edge after which a step wrapped (up from MAX_COUNT, or down from 0). `load` or injection that cycle suppresses `tc`.
- Error bookkeeping per replica i, each edge:
  - If `mismatch[i]`, set `err_sticky[i]` and increment `err_cnt[i]`, saturating at 2**ERR_W-1.
  - `clr_err` zeroes the sticky flag and counter. A simultaneous mismatch wins: the flag ends at 1 and the count at 1.
- `uncorrectable` sets on any edge where all three replicas differ. It is cleared by `clr_err`, with set winning over clear.
- Reset values: r0..r2 = 0, `q` = 0, `tc` = 0, `err_sticky` = 0, `err_cnt` = 0, `uncorrectable` = 0, `alarm` = 0, `mismatch` = 0.
- Reset mid-operation takes effect on that edge and overrides `load`, `en`, injection and `clr_err`.

## Timing
- Count latency: `en` sampled at edge k → `q` updates right after edge k.
- Injection into one replica at edge k:
  - `mismatch[i]` asserts in cycle k→k+1.
  - The replica is corrected, and the sticky flag and counter update, at edge k+1.
  - `q` never changes due to the injection.
- Injection in the same cycle as `en`: the non-injected replicas step, so the scrub happens against the stepped vote.
- Injection into two replicas with an identical mask at edge k: `q` is corrupted from k until k+1, when the remaining replica is overwritten by the step/hold of the corrupt vote. This is the documented limit of TMR.

## Structure
- Package `tmr_pkg`:
  - constant `NREP = 3`
  - function `maj3` (bitwise majority)
  - typedef `rep_idx_t` (logic [1:0]) for the replica index.
- Sub-module `tmr_voter3` (parameter WIDTH): inputs r0..r2; outputs v, `mismatch[2:0]` and all-differ.
- The top instantiates the voter once and generates the three replica registers and error counters.

## Test plan
- Reset, then 10 cycles of `en` with up, WIDTH=8, MAX_COUNT=9 → `q` runs 1..9, then 0; `tc` is high in the cycle `q` returns to 0.
- Down from 0 with MAX_COUNT=9 → `q`=9 and `tc`=1. `load` with `load_val`=200 → `q`=9 (clamped).
- `inj_en`=3'b010, `inj_bits`=8'h81 with `en`=0 → `q` is stable; `mismatch`=3'b010 for exactly one cycle; `err_sticky`=3'b010; `err_cnt[1]`=1.
- Four single injections into replica 0 with ERR_THRESH=4 → `alarm` asserts after the 4th. Then `clr_err` → counter 0 and `alarm` deasserts.
- `inj_en`=3'b111 with masks giving three distinct values → `uncorrectable` is set and stays set until `clr_err`.
- `rst` asserted during an injection and `load` in the same cycle → all outputs are 0 next cycle and `err_cnt` stays 0.
